// File: rtl/cpu_pkg.sv
// Shared types for the CPU front end: instruction width, opcodes, fetch queue entry, fetch FSM.
package cpu_pkg;

  localparam int INSTR_W = 16;

  typedef logic [3:0] opcode_t;

  localparam opcode_t HLT_OP = 4'hF;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [7:0]         pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    RUN,
    STOP,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue: DEPTH-entry FIFO with flush; head is a combinational read, push/pop take effect at the edge.
// No internal backpressure: the writer must not push when full unless it pops in the same cycle.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   push_dat,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      assert (!(push && full && !pop));
      assert (!(pop && empty));
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns fetch PC, one imem read per cycle, queues {instr, pc} for dispatch; request-to-out_valid is 2 cycles.
// Stalls requests when queue plus in-flight would overflow; FETCH_BYPASS_EN lets a response reach out_* in its arrival cycle.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter int         INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [7:0]         imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [7:0]         out_pc,
  input  logic               redirect_valid,
  input  logic [7:0]         redirect_pc,
  output logic               hlt,
  output logic [7:0]         pc
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [7:0]         pc;
  } entry_t;

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic [7:0]    fetch_pc;
  logic [7:0]    inflight_pc;
  logic          inflight;
  logic          started;
  logic          hlt_q;

  logic [CW-1:0] q_count;
  logic [CW:0]   occ;
  logic          q_full;
  logic          q_empty;
  logic          q_push;
  logic          q_pop;
  entry_t        q_head;
  entry_t        resp;
  entry_t        sel;
  logic          sel_vld;

  logic          redirect_act;
  logic          resp_hlt;
  logic          head_hlt;
  logic          issue;
  logic          pop;

  assign redirect_act = redirect_valid && (state != HALTED);
  assign resp         = '{instr: imem_rdata, pc: inflight_pc};
  assign resp_hlt     = inflight && (imem_rdata[INSTR_W-1 -: 4] == HLT_OP);
  assign occ          = {1'b0, q_count} + {{CW{1'b0}}, inflight};

  // A HLT arriving this cycle blocks the request that would otherwise follow it.
  assign issue = started && (state == RUN) && !redirect_act && !resp_hlt &&
                 !q_full && (occ < (CW+1)'(DEPTH));

`ifdef FETCH_BYPASS_EN
  assign sel_vld = q_empty ? inflight : 1'b1;
  assign sel     = q_empty ? resp : q_head;
  assign q_push  = inflight && !redirect_act && !(pop && q_empty);
`else
  assign sel_vld = !q_empty;
  assign sel     = q_head;
  assign q_push  = inflight && !redirect_act;
`endif

  assign out_valid = sel_vld && !redirect_act;
  assign pop       = out_valid && out_ready;
  assign q_pop     = pop && !q_empty;
  assign head_hlt  = pop && (sel.instr[INSTR_W-1 -: 4] == HLT_OP);

  assign out_instr = out_valid ? sel.instr : '0;
  assign out_pc    = out_valid ? sel.pc : '0;
  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign pc        = fetch_pc;
  assign hlt       = hlt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      started     <= 1'b0;
      hlt_q       <= 1'b0;
    end else begin
      started  <= 1'b1;
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
      if (redirect_act) begin
        state    <= RUN;
        fetch_pc <= redirect_pc;
      end else begin
        if (head_hlt) begin
          state <= HALTED;
          hlt_q <= 1'b1;
        end else if (resp_hlt && (state == RUN)) begin
          state <= STOP;
        end
        // Park the PC on the HLT so a later redirect/restart sees where fetch stopped.
        if (resp_hlt)   fetch_pc <= inflight_pc;
        else if (issue) fetch_pc <= fetch_pc + 8'd1;
      end
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_act),
    .push     (q_push),
    .push_dat (resp),
    .pop      (q_pop),
    .head     (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirect, HLT, PC wrap and mid-stream reset.
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        hlt;
  logic [7:0]  pc;

  logic        fe_imem_req;
  logic [7:0]  fe_imem_addr;
  logic [15:0] fe_imem_rdata;
  logic        fe_out_valid;
  logic        fe_out_ready;
  logic [15:0] fe_out_instr;
  logic [7:0]  fe_out_pc;
  logic        fe_redirect_valid;
  logic [7:0]  fe_redirect_pc;
  logic        fe_hlt;
  logic [7:0]  fe_pc;

  logic [15:0] mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .hlt            (hlt),
    .pc             (pc)
  );

  fetch_unit #(.RESET_PC(8'hFE)) u_dut_fe (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (fe_imem_req),
    .imem_addr      (fe_imem_addr),
    .imem_rdata     (fe_imem_rdata),
    .out_valid      (fe_out_valid),
    .out_ready      (fe_out_ready),
    .out_instr      (fe_out_instr),
    .out_pc         (fe_out_pc),
    .redirect_valid (fe_redirect_valid),
    .redirect_pc    (fe_redirect_pc),
    .hlt            (fe_hlt),
    .pc             (fe_pc)
  );

  // Synchronous instruction memory: data one cycle after the request.
  always @(posedge clk) begin
    imem_rdata    <= imem_req    ? mem[imem_addr]    : 16'hBEEF;
    fe_imem_rdata <= fe_imem_req ? mem[fe_imem_addr] : 16'hBEEF;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   imem_req,  0);
    chk({tag, "_vld"},   out_valid, 0);
    chk({tag, "_instr"}, out_instr, 0);
    chk({tag, "_opc"},   out_pc,    0);
    chk({tag, "_hlt"},   hlt,       0);
    chk({tag, "_pc"},    pc,        0);
  endtask

  initial begin
    logic [7:0] e8;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
    mem[7] = 16'hF007;

    fe_out_ready      = 1'b1;
    fe_redirect_valid = 1'b0;
    fe_redirect_pc    = 8'h00;
    out_ready         = 1'b0;
    rst_n             = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = 8'h00;

    // Reset state.
    cyc();
    cyc();
    smp();
    chk_reset_outputs("rst");

    // Streaming with out_ready high; second instance shows the PC wrap from FE.
    out_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      cyc();
      smp();
      chk("t1_req", imem_req, 1);
      chk("t1_addr", imem_addr, c - 1);
      e8 = 8'hFE + 8'(c - 1);
      chk("fe_addr", fe_imem_addr, e8);
      chk("t1_vld", out_valid, (c >= LAT + 1) ? 1 : 0);
      if (c >= LAT + 1) begin
        chk("t1_pc", out_pc, c - 1 - LAT);
        chk("t1_instr", out_instr, 32'h1000 + (c - 1 - LAT));
      end
    end

    // Backpressure: exactly DEPTH entries, then ordered drain and fetch resumes.
    out_ready = 1'b0;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      cyc();
      smp();
      chk("t2_req", imem_req, (c <= 4) ? 1 : 0);
      if (c <= 4) chk("t2_addr", imem_addr, c - 1);
    end
    chk("t2_vld", out_valid, 1);
    chk("t2_pc", out_pc, 0);
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      smp();
      chk("t2_dvld", out_valid, 1);
      chk("t2_dpc", out_pc, k);
      if (k == 1) begin
        chk("t2_resume_req", imem_req, 1);
        chk("t2_resume_addr", imem_addr, 4);
      end
    end

    // Reset asserted with a full queue.
    out_ready = 1'b0;
    do_reset();
    repeat (6) cyc();
    smp();
    chk("t6_full_vld", out_valid, 1);
    chk("t6_full_req", imem_req, 0);
    cyc();
    rst_n = 1'b0;
    cyc();
    smp();
    chk_reset_outputs("t6");

    // Redirect with 3 queued entries and one request in flight.
    out_ready = 1'b0;
    do_reset();
    repeat (4) cyc();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    out_ready      = 1'b1;
    smp();
    chk("t3_rvld", out_valid, 0);
    chk("t3_rreq", imem_req, 0);
    cyc();
    redirect_valid = 1'b0;
    smp();
    chk("t3_req", imem_req, 1);
    chk("t3_addr", imem_addr, 8'h40);
    chk("t3_vld0", out_valid, 0);
    for (int c = 7; c <= 11; c++) begin
      cyc();
      smp();
      chk("t3_vld", out_valid, (c >= 6 + LAT) ? 1 : 0);
      if (c >= 6 + LAT) chk("t3_pc", out_pc, 8'h40 + (c - 6 - LAT));
    end

    // HLT at 8'h07 after a redirect to 8'h05.
    out_ready = 1'b0;
    do_reset();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 8'h05;
    smp();
    chk("t4_rreq", imem_req, 0);
    cyc();
    redirect_valid = 1'b0;
    smp();
    chk("t4_a5", imem_addr, 8'h05);
    chk("t4_r5", imem_req, 1);
    cyc();
    smp();
    chk("t4_a6", imem_addr, 8'h06);
    cyc();
    smp();
    chk("t4_a7", imem_addr, 8'h07);
    chk("t4_r7", imem_req, 1);
    cyc();
    smp();
    chk("t4_stop_req", imem_req, 0);
    cyc();
    smp();
    chk("t4_stop_req2", imem_req, 0);
    chk("t4_pc", pc, 8'h07);
    chk("t4_vld", out_valid, 1);
    chk("t4_head", out_pc, 8'h05);
    chk("t4_hlt0", hlt, 0);
    cyc();
    out_ready = 1'b1;
    smp();
    chk("t4_d5", out_pc, 8'h05);
    chk("t4_dreq", imem_req, 0);
    cyc();
    smp();
    chk("t4_d6", out_pc, 8'h06);
    cyc();
    smp();
    chk("t4_d7", out_pc, 8'h07);
    chk("t4_d7i", out_instr, 16'hF007);
    chk("t4_hlt_pre", hlt, 0);
    cyc();
    smp();
    chk("t4_hlt", hlt, 1);
    chk("t4_empty", out_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h20;
    cyc();
    redirect_valid = 1'b0;
    smp();
    chk("t4_hlt_sticky", hlt, 1);
    chk("t4_ign_req", imem_req, 0);
    chk("t4_ign_pc", pc, 8'h07);
    cyc();
    smp();
    chk("t4_ign_req2", imem_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
